// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream multiplexer: mode encodings and the
// packet-lock FSM state type.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester found searching
// cyclically upward from ptr, returned as a one-hot grant and an index.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] idx
);

    always_comb begin
        int  c;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 0; i < N_CH; i++) begin
            c = (int'(ptr) + i) % N_CH;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = SEL_W'(c);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with registered output, fixed-select or
// round-robin arbitration. Define STREAM_MUX_PKT_LOCK_EN to hold a grant for a whole packet.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH-1:0]   in_last,
    output logic [N_CH-1:0]   in_ready,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [W-1:0]     data_p1;
    logic [SEL_W-1:0] ch_p1;
    logic             vld_p1;
    logic [SEL_W-1:0] ptr;

    logic [N_CH-1:0]  rr_gnt;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;
    logic             fix_ok;
    logic             grant;
    logic [SEL_W-1:0] g;
    logic             load;
    logic             xfer;
    logic [W-1:0]     g_data;
    logic             ptr_upd;

    rr_arbiter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_arb (
        .req (in_valid),
        .ptr (ptr),
        .gnt (rr_gnt),
        .idx (rr_idx)
    );

    assign rr_any = |rr_gnt;

    // An out-of-range sel matches no channel and so never grants.
    always_comb begin
        fix_ok = 1'b0;
        for (int c = 0; c < N_CH; c++)
            if (sel == SEL_W'(c)) fix_ok = in_valid[c];
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_state_t      state;
    logic [SEL_W-1:0] lock_ch;
    logic             last_p1;
    logic             g_last;
    logic             lock_ok;

    always_comb begin
        g_last  = 1'b0;
        lock_ok = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (g == SEL_W'(c))       g_last  = in_last[c];
            if (lock_ch == SEL_W'(c)) lock_ok = in_valid[c];
        end
    end

    // Mid-packet beats leave ptr alone; the closing beat advances it.
    assign ptr_upd = (state == IDLE) || g_last;
`else
    logic unused_last;
    assign unused_last = ^in_last;
    assign ptr_upd     = 1'b1;
`endif

    always_comb begin
        grant = 1'b0;
        g     = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (state == LOCKED) begin
            grant = lock_ok;
            g     = lock_ch;
        end else
`endif
        if (mode == MODE_RR) begin
            grant = rr_any;
            g     = rr_idx;
        end else begin
            grant = fix_ok;
            g     = sel;
        end
    end

    assign load = !vld_p1 || out_ready;
    assign xfer = load && grant;

    always_comb begin
        in_ready = '0;
        g_data   = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (g == SEL_W'(c)) begin
                in_ready[c] = xfer && !rst;
                g_data      = in_data[c*W +: W];
            end
        end
    end

    // Output stage: one register entry, refilled in the same cycle it drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ch_p1   <= '0;
            ptr     <= '0;
        end else begin
            if (load) vld_p1 <= grant;
            if (xfer) begin
                data_p1 <= g_data;
                ch_p1   <= g;
            end
            if (xfer && (mode == MODE_RR) && ptr_upd)
                ptr <= (g == SEL_W'(N_CH - 1)) ? '0 : g + SEL_W'(1);
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lock_ch <= '0;
            last_p1 <= 1'b0;
        end else if (xfer) begin
            last_p1 <= g_last;
            case (state)
                IDLE: if (!g_last) begin
                    state   <= LOCKED;
                    lock_ch <= g;
                end
                LOCKED: if (g_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign out_last = last_p1;
`else
    assign out_last = 1'b0;
`endif

    assign out_data  = data_p1;
    assign out_ch    = ch_p1;
    assign out_valid = vld_p1;

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes on every input and a registered output. It has two run-time modes: fixed channel select, as in the combinational selector it succeeds, and fair round-robin arbitration. It sits between several producer streams and one shared consumer, such as a serialiser, FIFO or output port.

## Interface
- `N_CH`, 4, number of input channels (≥2)
- `W`, 8, data width per channel
- `SEL_W`, `$clog2(N_CH)`, channel index width
- `clk` input 1: single clock, rising edge
- `rst` input 1: asynchronous, active-high reset
- `mode` input 1: 0 = fixed select, 1 = round-robin
- `sel` input SEL_W: channel index used in fixed mode
- `in_data` input N_CH*W: channel c occupies bits [c*W +: W]
- `in_valid` input N_CH: per-channel valid
- `in_last` input N_CH: per-channel end-of-packet; used only with lock feature
- `in_ready` output N_CH: per-channel ready; at most one bit high
- `out_data` output W: registered data
- `out_ch` output SEL_W: source channel of `out_data`
- `out_last` output 1: registered last flag
- `out_valid` output 1: output register full
- `out_ready` input 1: consumer ready

## Operation
- Output stage is one register entry. `load = !out_valid || out_ready`.
- **Grant, fixed mode:**
  - `g = sel` when `in_valid[sel]` is high.
  - `sel ≥ N_CH` gives no grant.
- **Grant, round-robin mode:**
  - `g` is the first channel with `in_valid` high, searching cyclically from pointer `ptr` upward.
  - No valid channel gives no grant.
- `in_ready[g] = load && grant`. All other `in_ready` bits are 0.
- A beat transfers when `in_valid[g] && in_ready[g]`.
  - On transfer, the register captures `in_data[g]`, `g` and `in_last[g]`, and `out_valid` is set to 1.
  - If `load` is high and there is no transfer, `out_valid` is cleared.
- `ptr` updates only on a round-robin transfer, to `(g+1) mod N_CH`. The wrap from N_CH-1 goes to 0.
- In fixed mode `ptr` holds its value.
- `mode` and `sel` are sampled every cycle. A change takes effect on the next grant, except while locked (see Configuration).
- Simultaneous `out_ready` and new transfer: the register is overwritten in the same cycle, with no bubble.
- Registered output fields: `out_data`, `out_ch`, `out_last` hold their value while `out_valid && !out_ready`.

## Timing
- Latency: input transfer at edge k gives `out_valid` high after edge k. That is 1 cycle.
- Throughput: 1 beat/cycle with `out_ready` held high.
- `in_ready` is combinational from `in_valid`, `mode`, `sel`, lock state, `out_valid` and `out_ready`. There is no combinational path from `in_data` to outputs.
- **Reset values:**
  - `out_valid=0`, `out_data=0`, `out_ch=0`, `out_last=0`
  - `ptr=0`, lock state IDLE
  - `in_ready` forced to all 0 while `rst` is high
- **Reset mid-operation:** a pending output beat is discarded and any lock is released immediately. This is asynchronous.

## Configuration
- Macro: `STREAM_MUX_PKT_LOCK_EN`.
- **Defined:** a two-state FSM, IDLE and LOCKED.
  - IDLE → LOCKED on a transfer with `in_last[g]=0`; latch `lock_ch=g`.
  - LOCKED: the grant is `lock_ch` only, gated by `in_valid[lock_ch]`. `mode`, `sel` and other channels are ignored.
  - LOCKED → IDLE on a transfer with `in_last[lock_ch]=1`. In round-robin mode `ptr` becomes `lock_ch+1` at that point.
  - A transfer with `in_last=1` while IDLE stays IDLE (single-beat packet).
- **Undefined:** no FSM. `in_last` is ignored and `out_last` is tied to 0. Arbitration is per beat.

## Structure
- Shared package `stream_mux_pkg`: mode encoding constants (`MODE_FIXED=1'b0`, `MODE_RR=1'b1`) and the lock FSM state typedef (`IDLE`, `LOCKED`).
- One sub-module, `rr_arbiter`: parametrised by `N_CH`; request vector plus pointer in, one-hot grant plus index out. Purely combinational.
- The top level holds `ptr`, the lock FSM and the output register.

## Test plan
- **Fixed select:** N_CH=4, mode=0, sel=2, `in_valid=4'b0100`, `in_data[2]=8'hA5`, `out_ready=1` → `in_ready=4'b0100`; next cycle `out_data=8'hA5`, `out_ch=2`, `out_valid=1`.
- **Round-robin fairness:** mode=1, all `in_valid=1`, `out_ready=1` for 6 cycles → `out_ch` sequence 0,1,2,3,0,1, with no bubbles.
- **Backpressure:** output full, `out_ready=0` for 3 cycles → `in_ready=0`, `out_data` and `out_ch` stable; `out_ready=1` → next beat loads in the same cycle.
- **Sparse requests and invalid select:**
  - N_CH=3, mode=0, sel=3 → no `in_ready`, `out_valid` stays 0.
  - Round-robin with `ptr=2` and only ch0 valid → grant ch0, then `ptr=1`.
- **Packet lock** (`STREAM_MUX_PKT_LOCK_EN`): ch1 sends 3 beats with last on the 3rd while ch0 and ch2 are valid → `out_ch` 1,1,1, then 2. Changing `mode` mid-packet has no effect.
- **Async reset mid-packet:** assert `rst` between edges while LOCKED with `out_valid=1` → `out_valid=0` and all outputs 0 immediately. After release, `ptr=0` and the FSM is IDLE.
